tage_ghist_buffer: RTL and testbench

Speculative global and path history buffer for the TAGE predictor in the frontend. It consumes the history geometry from the core configuration (history buffer bits, path history bits) and supplies the predictor with the most recent branch outcomes. Each prediction receives a checkpoint of the history state. When the backend resolves a mispredicted branch, it sends that checkpoint back, and the buffer rewinds to it and inserts the corrected outcome.

---
 rtl/tage_ghist_buffer_pkg.sv | 27 ++
 rtl/tage_ghist_buffer.sv | 99 +++++++++
 tb/tb_tage_ghist_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tage_ghist_buffer_pkg.sv
// History geometry and checkpoint type shared by the TAGE frontend blocks.
// The path-history feature of the buffer is selected with TAGE_PATH_HIST_EN.
package tage_ghist_buffer_pkg;

    localparam int HIST_BUFFER_BITS = 256;
    localparam int MAX_HIST_LEN     = 64;
    localparam int PATH_HIST_BITS   = 16;
    localparam int PTR_W            = $clog2(HIST_BUFFER_BITS);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        ptr_t                      ptr;
        logic [PATH_HIST_BITS-1:0] path;
    } tage_ghist_ckpt_t;

    // Occupancy at which a further push could overwrite history a live checkpoint still needs.
    localparam ptr_t FULL_OCC = ptr_t'(HIST_BUFFER_BITS - MAX_HIST_LEN);

    function automatic logic [PATH_HIST_BITS-1:0] path_shift(
        input logic [PATH_HIST_BITS-1:0] path,
        input logic                      pc_bit
    );
        return {path[PATH_HIST_BITS-2:0], pc_bit};
    endfunction

endpackage

// File: rtl/tage_ghist_buffer.sv
// Speculative global/path history buffer with checkpoint rewind for TAGE.
// Define TAGE_PATH_HIST_EN to build the path history register; otherwise path outputs are 0.
module tage_ghist_buffer
    import tage_ghist_buffer_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      spec_valid_i,
    input  logic                      spec_taken_i,
    input  logic                      spec_pc_bit_i,
    output tage_ghist_ckpt_t          ckpt_o,
    input  logic                      restore_valid_i,
    input  tage_ghist_ckpt_t          restore_ckpt_i,
    input  logic                      restore_taken_i,
    input  logic                      restore_pc_bit_i,
    input  logic                      retire_i,
    output logic [MAX_HIST_LEN-1:0]   ghist_o,
    output logic [PATH_HIST_BITS-1:0] path_hist_o,
    output logic                      full_o
);

    logic [HIST_BUFFER_BITS-1:0] hist_buf;
    ptr_t                        ptr;
    ptr_t                        tail;
    ptr_t                        occupancy;
    logic [PATH_HIST_BITS-1:0]   path;

    logic wr_en;
    ptr_t wr_idx;
    logic wr_bit;

    // A restore rewrites the mispredicted slot and drops any same-cycle speculative push.
    always_comb begin
        wr_en  = spec_valid_i || restore_valid_i;
        wr_idx = restore_valid_i ? restore_ckpt_i.ptr : ptr;
        wr_bit = restore_valid_i ? restore_taken_i : spec_taken_i;
    end

    // NOTE: the history array is reset because ghist_o exposes every slot; a stale bit after reset would be a visible output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_buf <= '0;
            ptr      <= '0;
            tail     <= '0;
        end else begin
            if (wr_en) begin
                hist_buf[wr_idx] <= wr_bit;
                ptr              <= wr_idx + ptr_t'(1);
            end
            if (retire_i) begin
                tail <= tail + ptr_t'(1);
            end
        end
    end

`ifdef TAGE_PATH_HIST_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            path <= '0;
        end else if (restore_valid_i) begin
            path <= path_shift(restore_ckpt_i.path, restore_pc_bit_i);
        end else if (spec_valid_i) begin
            path <= path_shift(path, spec_pc_bit_i);
        end
    end
`else
    logic unused_path_inputs;
    assign unused_path_inputs = ^{spec_pc_bit_i, restore_pc_bit_i, restore_ckpt_i.path};
    assign path = '0;
`endif

    // Index arithmetic stays in pointer width so reads wrap across slot 0 naturally.
    always_comb begin
        ghist_o = '0;
        for (int i = 0; i < MAX_HIST_LEN; i++) begin
            ghist_o[i] = hist_buf[ptr - ptr_t'(i + 1)];
        end
    end

    assign occupancy   = ptr - tail;
    assign full_o      = (occupancy == FULL_OCC);
    assign path_hist_o = path;

    always_comb begin
        ckpt_o      = '0;
        ckpt_o.ptr  = ptr;
        ckpt_o.path = path;
    end

`ifndef SYNTHESIS
    push_while_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(spec_valid_i && !restore_valid_i && full_o));
    retire_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(retire_i && occupancy == '0));
    restore_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        restore_valid_i |-> ((restore_ckpt_i.ptr - tail) < occupancy));
`endif

endmodule

// File: tb/tb_tage_ghist_buffer.sv
// Self-checking bench for tage_ghist_buffer: reference model feeds a scoreboard queue.
module tb_tage_ghist_buffer;
    import tage_ghist_buffer_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_i;
    logic                      spec_valid_i, spec_taken_i, spec_pc_bit_i;
    tage_ghist_ckpt_t          ckpt_o;
    logic                      restore_valid_i;
    tage_ghist_ckpt_t          restore_ckpt_i;
    logic                      restore_taken_i, restore_pc_bit_i;
    logic                      retire_i;
    logic [MAX_HIST_LEN-1:0]   ghist_o;
    logic [PATH_HIST_BITS-1:0] path_hist_o;
    logic                      full_o;

    tage_ghist_buffer dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .spec_valid_i    (spec_valid_i),
        .spec_taken_i    (spec_taken_i),
        .spec_pc_bit_i   (spec_pc_bit_i),
        .ckpt_o          (ckpt_o),
        .restore_valid_i (restore_valid_i),
        .restore_ckpt_i  (restore_ckpt_i),
        .restore_taken_i (restore_taken_i),
        .restore_pc_bit_i(restore_pc_bit_i),
        .retire_i        (retire_i),
        .ghist_o         (ghist_o),
        .path_hist_o     (path_hist_o),
        .full_o          (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                     tag;
        logic [MAX_HIST_LEN-1:0]   ghist;
        logic [PATH_HIST_BITS-1:0] path;
        ptr_t                      ptr;
        logic                      full;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [HIST_BUFFER_BITS-1:0] m_buf;
    ptr_t                        m_ptr, m_tail;
    logic [PATH_HIST_BITS-1:0]   m_path;
    logic [PATH_HIST_BITS-1:0]   ck_path [HIST_BUFFER_BITS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PATH_HIST_BITS-1:0] model_path(
        input logic [PATH_HIST_BITS-1:0] p, input logic b);
`ifdef TAGE_PATH_HIST_EN
        return {p[PATH_HIST_BITS-2:0], b};
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_buf  = '0;
        m_ptr  = '0;
        m_tail = '0;
        m_path = '0;
        for (int k = 0; k < HIST_BUFFER_BITS; k++) ck_path[k] = '0;
    endtask

    function automatic exp_t model_expect(input string tag);
        exp_t e;
        e.tag = tag;
        for (int i = 0; i < MAX_HIST_LEN; i++) begin
            ptr_t idx;
            idx        = m_ptr - ptr_t'(i + 1);
            e.ghist[i] = m_buf[idx];
        end
        e.path = m_path;
        e.ptr  = m_ptr;
        e.full = ((m_ptr - m_tail) == ptr_t'(HIST_BUFFER_BITS - MAX_HIST_LEN));
        return e;
    endfunction

    task automatic drive_idle();
        spec_valid_i     = 1'b0;
        spec_taken_i     = 1'b0;
        spec_pc_bit_i    = 1'b0;
        restore_valid_i  = 1'b0;
        restore_ckpt_i   = '0;
        restore_taken_i  = 1'b0;
        restore_pc_bit_i = 1'b0;
        retire_i         = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, then compare one cycle later.
    task automatic step(input logic sv, input logic st, input logic spc,
                        input logic rv, input ptr_t rptr, input logic rt, input logic rpc,
                        input logic ret, input string tag);
        exp_t e;
        spec_valid_i        = sv;
        spec_taken_i        = st;
        spec_pc_bit_i       = spc;
        restore_valid_i     = rv;
        restore_ckpt_i.ptr  = rptr;
        restore_ckpt_i.path = ck_path[rptr];
        restore_taken_i     = rt;
        restore_pc_bit_i    = rpc;
        retire_i            = ret;
        if (rv) begin
            m_buf[rptr] = rt;
            m_ptr       = rptr + ptr_t'(1);
            m_path      = model_path(ck_path[rptr], rpc);
        end else if (sv) begin
            ck_path[m_ptr] = m_path;
            m_buf[m_ptr]   = st;
            m_ptr          = m_ptr + ptr_t'(1);
            m_path         = model_path(m_path, spc);
        end
        if (ret) m_tail = m_tail + ptr_t'(1);
        exp_q.push_back(model_expect(tag));
        @(posedge clk);
        #1;
        drive_idle();
        e = exp_q.pop_front();
        check({e.tag, ".ghist"}, 64'(ghist_o), 64'(e.ghist));
        check({e.tag, ".path"}, 64'(path_hist_o), 64'(e.path));
        check({e.tag, ".ckpt_ptr"}, 64'(ckpt_o.ptr), 64'(e.ptr));
        check({e.tag, ".ckpt_path"}, 64'(ckpt_o.path), 64'(e.path));
        check({e.tag, ".full"}, 64'(full_o), 64'(e.full));
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst_i = 1'b1;
        #1;
        check({tag, ".rst_ghist"}, 64'(ghist_o), 64'd0);
        check({tag, ".rst_path"}, 64'(path_hist_o), 64'd0);
        check({tag, ".rst_ckpt"}, 64'(ckpt_o), 64'd0);
        check({tag, ".rst_full"}, 64'(full_o), 64'd0);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        model_reset();
        rst_i = 1'b1;
        #12;
        check("reset.ghist", 64'(ghist_o), 64'd0);
        check("reset.path", 64'(path_hist_o), 64'd0);
        check("reset.ckpt", 64'(ckpt_o), 64'd0);
        check("reset.full", 64'(full_o), 64'd0);
        rst_i = 1'b0;

        // Taken, not-taken, taken with pc bits 1,1,0.
        step(1, 1, 1, 0, '0, 0, 0, 0, "basic0");
        step(1, 0, 1, 0, '0, 0, 0, 0, "basic1");
        step(1, 1, 0, 0, '0, 0, 0, 0, "basic2");
        check("basic.ghist3", 64'(ghist_o[2:0]), 64'(3'b101));
        check("basic.ptr", 64'(ckpt_o.ptr), 64'd3);
`ifdef TAGE_PATH_HIST_EN
        check("basic.path3", 64'(path_hist_o[2:0]), 64'(3'b110));
`else
        check("basic.path_off", 64'(path_hist_o), 64'd0);
`endif

        // Five pushes, then rewind to the second branch with the corrected direction.
        do_reset("restore");
        step(1, 1, 0, 0, '0, 0, 0, 0, "rs_push0");
        step(1, 0, 1, 0, '0, 0, 0, 0, "rs_push1");
        step(1, 0, 0, 0, '0, 0, 0, 0, "rs_push2");
        step(1, 1, 1, 0, '0, 0, 0, 0, "rs_push3");
        step(1, 1, 0, 0, '0, 0, 0, 0, "rs_push4");
        step(0, 0, 0, 1, ptr_t'(1), 1, 1, 0, "rs_restore");
        check("restore.ptr", 64'(ckpt_o.ptr), 64'd2);
        check("restore.ghist2", 64'(ghist_o[1:0]), 64'(2'b11));

        // Restore and speculative push in the same cycle.
        do_reset("collide");
        for (int i = 0; i < 4; i++) step(1, 1'(i & 1), 1'(i >> 1), 0, '0, 0, 0, 0, "cl_push");
        step(1, 0, 1, 1, ptr_t'(2), 1, 0, 0, "cl_both");
        check("collide.ptr", 64'(ckpt_o.ptr), 64'd3);

        // Fill to the wrap with a one-behind retire, then cross slot 0.
        do_reset("wrap");
        for (int i = 0; i < HIST_BUFFER_BITS - 1; i++)
            step(1, 1'(((i * 7) % 5) < 2), 1'(i % 3 == 0), 0, '0, 0, 0, 1'(i > 0), "wr_fill");
        check("wrap.pre_ptr", 64'(ckpt_o.ptr), 64'd255);
        step(1, 1, 1, 0, '0, 0, 0, 1, "wr_cross0");
        check("wrap.zero_ptr", 64'(ckpt_o.ptr), 64'd0);
        step(1, 0, 0, 0, '0, 0, 0, 1, "wr_cross1");
        check("wrap.one_ptr", 64'(ckpt_o.ptr), 64'd1);

        // Occupancy limit: 192 pushes assert full, one retire releases it.
        do_reset("full");
        for (int i = 0; i < HIST_BUFFER_BITS - MAX_HIST_LEN; i++)
            step(1, 1'(i % 3 == 1), 1'(i & 1), 0, '0, 0, 0, 0, "fl_push");
        check("full.set", 64'(full_o), 64'd1);
        step(0, 0, 0, 0, '0, 0, 0, 1, "fl_retire");
        check("full.clear", 64'(full_o), 64'd0);

        check("scoreboard.drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
